// File: rtl/if_pc_gen_pkg.sv
// Shared definitions for the fetch-stage PC generator: state encoding and
// the stall-vector layout seen from the IF stage.
package if_pc_gen_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_SLEEP = 2'd3
    } pc_state_t;

    localparam int          FETCH_BYTES_DEF = 8;
    localparam int          IF_STALL_BIT    = 0;
    localparam logic [4:0]  STALL_WFI       = 5'b11111;

endpackage

// File: rtl/if_pc_gen_redirect_hold.sv
// Pending-redirect register: holds a redirect that arrived while IF could not
// take it. An exception always overwrites; a branch never displaces an exception.
module if_redirect_hold
    import if_pc_gen_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  capture_excp,
    input  logic [ADDR_WIDTH-1:0] excp_pc,
    input  logic                  capture_branch,
    input  logic [ADDR_WIDTH-1:0] branch_pc,
    output logic                  pending_valid,
    output logic [ADDR_WIDTH-1:0] pending_pc,
    output logic                  pending_excp
);

    // Clear wins over capture: a redirect arriving on the release cycle is
    // applied directly by the top level, never parked here.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pending_valid <= 1'b0;
            pending_pc    <= '0;
            pending_excp  <= 1'b0;
        end else if (capture_excp) begin
            pending_valid <= 1'b1;
            pending_pc    <= excp_pc;
            pending_excp  <= 1'b1;
        end else if (capture_branch && !(pending_valid && pending_excp)) begin
            pending_valid <= 1'b1;
            pending_pc    <= branch_pc;
            pending_excp  <= 1'b0;
        end
    end

endmodule

// File: rtl/if_pc_gen.sv
// Fetch PC generator: sequential advance, branch/exception redirect, IF-stall
// redirect parking, WFI sleep and a saturating redirect counter.
module if_pc_gen
    import if_pc_gen_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    FETCH_BYTES = FETCH_BYTES_DEF,
    parameter int                    CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            Ctrl_Stall,
    input  logic                  EX_BranchFlag,
    input  logic [ADDR_WIDTH-1:0] EX_BranchPC,
    input  logic                  Csr_ExcpFlag,
    input  logic [ADDR_WIDTH-1:0] Csr_ExcpPC,
    input  logic [3:0]            Id_AdvBytes,
    output logic [ADDR_WIDTH-1:0] If_PC,
    output logic                  If_Valid,
    output logic                  If_Redirected,
    output logic [CNT_WIDTH-1:0]  Redirect_Cnt
);

    pc_state_t             state;
    logic                  if_stall;
    logic                  sleep_req;
    logic                  fresh_redirect;
    logic [ADDR_WIDTH-1:0] fresh_target;
    logic [ADDR_WIDTH-1:0] release_target;
    logic [ADDR_WIDTH-1:0] apply_target;
    logic                  apply_en;
    logic [ADDR_WIDTH-1:0] adv_bytes;
    logic                  capture_excp;
    logic                  capture_branch;
    logic                  clear_pending;
    logic                  pending_valid;
    logic [ADDR_WIDTH-1:0] pending_pc;
    logic                  pending_excp;

    assign if_stall       = Ctrl_Stall[IF_STALL_BIT];
    assign sleep_req      = (Ctrl_Stall == STALL_WFI);
    assign fresh_redirect = Csr_ExcpFlag | EX_BranchFlag;
    assign fresh_target   = Csr_ExcpFlag ? Csr_ExcpPC : EX_BranchPC;

    // On release a fresh exception wins; a parked exception outranks a fresh branch.
    always_comb begin
        release_target = pending_pc;
        if (Csr_ExcpFlag) begin
            release_target = Csr_ExcpPC;
        end else if (!pending_excp && EX_BranchFlag) begin
            release_target = EX_BranchPC;
        end
    end

    always_comb begin
        adv_bytes = ADDR_WIDTH'({Id_AdvBytes[3:1], 1'b0});
        if (Id_AdvBytes > 4'(FETCH_BYTES)) begin
            adv_bytes = ADDR_WIDTH'(FETCH_BYTES);
        end
    end

    always_comb begin
        capture_excp   = 1'b0;
        capture_branch = 1'b0;
        clear_pending  = 1'b0;
        apply_en       = 1'b0;
        apply_target   = fresh_target & ~ADDR_WIDTH'(1);
        case (state)
            ST_RUN: begin
                capture_excp   = if_stall & Csr_ExcpFlag;
                capture_branch = if_stall & EX_BranchFlag;
                apply_en       = ~if_stall & fresh_redirect;
            end
            ST_HOLD: begin
                capture_excp   = if_stall & Csr_ExcpFlag;
                capture_branch = if_stall & EX_BranchFlag;
                clear_pending  = ~if_stall;
                apply_en       = ~if_stall;
                apply_target   = release_target & ~ADDR_WIDTH'(1);
            end
            ST_SLEEP: begin
                capture_excp = Csr_ExcpFlag;
            end
            default: ;
        endcase
    end

    if_redirect_hold #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_hold (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear_pending),
        .capture_excp  (capture_excp),
        .excp_pc       (Csr_ExcpPC),
        .capture_branch(capture_branch),
        .branch_pc     (EX_BranchPC),
        .pending_valid (pending_valid),
        .pending_pc    (pending_pc),
        .pending_excp  (pending_excp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_BOOT;
            If_PC         <= RESET_PC;
            If_Valid      <= 1'b0;
            If_Redirected <= 1'b0;
            Redirect_Cnt  <= '0;
        end else begin
            If_Redirected <= 1'b0;
            if (apply_en) begin
                If_PC         <= apply_target;
                If_Valid      <= 1'b1;
                If_Redirected <= 1'b1;
                state         <= ST_RUN;
                if (Redirect_Cnt != {CNT_WIDTH{1'b1}}) begin
                    Redirect_Cnt <= Redirect_Cnt + CNT_WIDTH'(1);
                end
            end else begin
                case (state)
                    ST_BOOT: begin
                        state    <= ST_RUN;
                        If_Valid <= 1'b1;
                    end
                    ST_RUN: begin
                        if (if_stall) begin
                            if (fresh_redirect) begin
                                If_Valid <= 1'b0;
                            end
                            if (sleep_req) begin
                                state <= ST_SLEEP;
                            end else if (fresh_redirect) begin
                                state <= ST_HOLD;
                            end
                        end else begin
                            If_PC <= If_PC + adv_bytes;
                        end
                    end
                    ST_HOLD: begin
                        if (sleep_req) begin
                            state <= ST_SLEEP;
                        end
                    end
                    ST_SLEEP: begin
                        // A wake-up interrupt parks in the hold register and is applied from HOLD.
                        if (!sleep_req) begin
                            if (pending_valid || Csr_ExcpFlag) begin
                                state    <= ST_HOLD;
                                If_Valid <= 1'b0;
                            end else begin
                                state    <= ST_RUN;
                                If_Valid <= 1'b1;
                            end
                        end else if (Csr_ExcpFlag) begin
                            If_Valid <= 1'b0;
                        end
                    end
                    default: state <= ST_BOOT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_pc_gen.sv
// Scoreboard bench for if_pc_gen: directed vectors push expected outputs,
// a monitor pops and compares them one cycle after the stimulus edge.
module tb_if_pc_gen;

    logic        clk;
    logic        rst;
    logic [4:0]  Ctrl_Stall;
    logic        EX_BranchFlag;
    logic [31:0] EX_BranchPC;
    logic        Csr_ExcpFlag;
    logic [31:0] Csr_ExcpPC;
    logic [3:0]  Id_AdvBytes;
    logic [31:0] If_PC;
    logic        If_Valid;
    logic        If_Redirected;
    logic [2:0]  Redirect_Cnt;

    typedef struct {
        int          cyc;
        string       name;
        logic [31:0] pc;
        logic        valid;
        logic        redir;
        logic [2:0]  cnt;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    if_pc_gen #(
        .ADDR_WIDTH (32),
        .RESET_PC   (32'h0000_1000),
        .FETCH_BYTES(8),
        .CNT_WIDTH  (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .Ctrl_Stall   (Ctrl_Stall),
        .EX_BranchFlag(EX_BranchFlag),
        .EX_BranchPC  (EX_BranchPC),
        .Csr_ExcpFlag (Csr_ExcpFlag),
        .Csr_ExcpPC   (Csr_ExcpPC),
        .Id_AdvBytes  (Id_AdvBytes),
        .If_PC        (If_PC),
        .If_Valid     (If_Valid),
        .If_Redirected(If_Redirected),
        .Redirect_Cnt (Redirect_Cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Drives one cycle of inputs at the falling edge and queues the outputs
    // expected after the following rising edge.
    task automatic applyStimulus(input logic r, input logic [4:0] st,
                                 input logic bf, input logic [31:0] bpc,
                                 input logic ef, input logic [31:0] epc,
                                 input logic [3:0] adv, input string name,
                                 input logic [31:0] pc, input logic v,
                                 input logic rd, input logic [2:0] cnt);
        exp_t x;
        @(negedge clk);
        rst           = r;
        Ctrl_Stall    = st;
        EX_BranchFlag = bf;
        EX_BranchPC   = bpc;
        Csr_ExcpFlag  = ef;
        Csr_ExcpPC    = epc;
        Id_AdvBytes   = adv;
        x.cyc   = cyc + 1;
        x.name  = name;
        x.pc    = pc;
        x.valid = v;
        x.redir = rd;
        x.cnt   = cnt;
        sb.push_back(x);
    endtask

    task automatic checkOutput(input exp_t x);
        checks++;
        if (If_PC !== x.pc || If_Valid !== x.valid || If_Redirected !== x.redir ||
            Redirect_Cnt !== x.cnt) begin
            failures++;
            $display("[TB] FAIL %s: got pc=%h valid=%b redir=%b cnt=%0d, expected pc=%h valid=%b redir=%b cnt=%0d",
                     x.name, If_PC, If_Valid, If_Redirected, Redirect_Cnt,
                     x.pc, x.valid, x.redir, x.cnt);
        end
    endtask

    // Monitor: compares every queued expectation whose cycle has arrived.
    always @(posedge clk) begin
        #2;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checkOutput(e);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1; Ctrl_Stall = 5'b0; EX_BranchFlag = 1'b0; EX_BranchPC = '0;
        Csr_ExcpFlag = 1'b0; Csr_ExcpPC = '0; Id_AdvBytes = 4'd8;

        //             rst  stall     bf   bpc           ef   epc     adv   name           pc            v     rd    cnt
        applyStimulus(1'b1, 5'b00000, 1'b0, 32'h0,        1'b0, 32'h0,   4'd8, "reset",       32'h1000,     1'b0, 1'b0, 3'd0);
        applyStimulus(1'b0, 5'b00000, 1'b0, 32'h0,        1'b0, 32'h0,   4'd8, "boot",        32'h1000,     1'b1, 1'b0, 3'd0);
        applyStimulus(1'b0, 5'b00000, 1'b0, 32'h0,        1'b0, 32'h0,   4'd8, "seq8_a",      32'h1008,     1'b1, 1'b0, 3'd0);
        applyStimulus(1'b0, 5'b00000, 1'b0, 32'h0,        1'b0, 32'h0,   4'd8, "seq8_b",      32'h1010,     1'b1, 1'b0, 3'd0);
        applyStimulus(1'b0, 5'b00000, 1'b1, 32'h2000,     1'b0, 32'h0,   4'd8, "br_2000",     32'h2000,     1'b1, 1'b1, 3'd1);
        applyStimulus(1'b0, 5'b00000, 1'b0, 32'h0,        1'b0, 32'h0,   4'd6, "adv6",        32'h2006,     1'b1, 1'b0, 3'd1);
        applyStimulus(1'b0, 5'b00000, 1'b0, 32'h0,        1'b0, 32'h0,   4'd2, "adv2",        32'h2008,     1'b1, 1'b0, 3'd1);
        applyStimulus(1'b0, 5'b00000, 1'b0, 32'h0,        1'b0, 32'h0,   4'd4, "adv4",        32'h200C,     1'b1, 1'b0, 3'd1);
        applyStimulus(1'b0, 5'b00000, 1'b0, 32'h0,        1'b0, 32'h0,  4'd15, "adv_clamp",   32'h2014,     1'b1, 1'b0, 3'd1);
        applyStimulus(1'b0, 5'b00000, 1'b0, 32'h0,        1'b0, 32'h0,   4'd0, "adv0",        32'h2014,     1'b1, 1'b0, 3'd1);
        applyStimulus(1'b0, 5'b00000, 1'b1, 32'h3001,     1'b0, 32'h0,   4'd8, "br_3001",     32'h3000,     1'b1, 1'b1, 3'd2);
        applyStimulus(1'b0, 5'b00000, 1'b0, 32'h0,        1'b0, 32'h0,   4'd0, "redir_pulse", 32'h3000,     1'b1, 1'b0, 3'd2);
        // Branch while IF is stalled for three cycles.
        applyStimulus(1'b0, 5'b00001, 1'b1, 32'h4000,     1'b0, 32'h0,   4'd8, "stall_br",    32'h3000,     1'b0, 1'b0, 3'd2);
        applyStimulus(1'b0, 5'b00001, 1'b0, 32'h0,        1'b0, 32'h0,   4'd8, "hold_1",      32'h3000,     1'b0, 1'b0, 3'd2);
        applyStimulus(1'b0, 5'b00001, 1'b0, 32'h0,        1'b0, 32'h0,   4'd8, "hold_2",      32'h3000,     1'b0, 1'b0, 3'd2);
        applyStimulus(1'b0, 5'b00000, 1'b0, 32'h0,        1'b0, 32'h0,   4'd8, "release_br",  32'h4000,     1'b1, 1'b1, 3'd3);
        applyStimulus(1'b0, 5'b00000, 1'b0, 32'h0,        1'b0, 32'h0,   4'd8, "after_rel",   32'h4008,     1'b1, 1'b0, 3'd3);
        // Branch then exception while stalled: exception wins.
        applyStimulus(1'b0, 5'b00001, 1'b1, 32'h5000,     1'b0, 32'h0,   4'd8, "bx_br",       32'h4008,     1'b0, 1'b0, 3'd3);
        applyStimulus(1'b0, 5'b00001, 1'b0, 32'h0,        1'b1, 32'h80,  4'd8, "bx_ex",       32'h4008,     1'b0, 1'b0, 3'd3);
        applyStimulus(1'b0, 5'b00000, 1'b0, 32'h0,        1'b0, 32'h0,   4'd8, "bx_release",  32'h0080,     1'b1, 1'b1, 3'd4);
        applyStimulus(1'b0, 5'b00000, 1'b0, 32'h0,        1'b0, 32'h0,   4'd8, "seq_88",      32'h0088,     1'b1, 1'b0, 3'd4);
        // Exception then branch while stalled: exception still wins.
        applyStimulus(1'b0, 5'b00001, 1'b0, 32'h0,        1'b1, 32'h80,  4'd8, "xb_ex",       32'h0088,     1'b0, 1'b0, 3'd4);
        applyStimulus(1'b0, 5'b00001, 1'b1, 32'h6000,     1'b0, 32'h0,   4'd8, "xb_br",       32'h0088,     1'b0, 1'b0, 3'd4);
        applyStimulus(1'b0, 5'b00000, 1'b0, 32'h0,        1'b0, 32'h0,   4'd8, "xb_release",  32'h0080,     1'b1, 1'b1, 3'd5);
        // Fresh exception on the release cycle beats the parked branch.
        applyStimulus(1'b0, 5'b00001, 1'b1, 32'h7000,     1'b0, 32'h0,   4'd8, "fr_br",       32'h0080,     1'b0, 1'b0, 3'd5);
        applyStimulus(1'b0, 5'b00000, 1'b0, 32'h0,        1'b1, 32'h200, 4'd8, "fr_release",  32'h0200,     1'b1, 1'b1, 3'd6);
        // WFI sleep for ten cycles with a wake-up interrupt at the fourth.
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b0, 5'b11111, 1'b0, 32'h0, (i == 4), 32'h100, 4'd8, "wfi",
                          32'h0200, (i < 4), 1'b0, 3'd6);
        end
        applyStimulus(1'b0, 5'b00000, 1'b0, 32'h0,        1'b0, 32'h0,   4'd8, "wfi_exit",    32'h0200,     1'b0, 1'b0, 3'd6);
        applyStimulus(1'b0, 5'b00000, 1'b0, 32'h0,        1'b0, 32'h0,   4'd8, "wfi_wake",    32'h0100,     1'b1, 1'b1, 3'd7);
        // Counter saturates, PC wraps modulo 2^32.
        applyStimulus(1'b0, 5'b00000, 1'b1, 32'hFFFF_FFF9, 1'b0, 32'h0,  4'd8, "cnt_sat",     32'hFFFF_FFF8, 1'b1, 1'b1, 3'd7);
        applyStimulus(1'b0, 5'b00000, 1'b0, 32'h0,        1'b0, 32'h0,   4'd8, "pc_wrap",     32'h0000_0000, 1'b1, 1'b0, 3'd7);
        // Reset asserted while a redirect is parked in HOLD.
        applyStimulus(1'b0, 5'b00001, 1'b1, 32'h9000,     1'b0, 32'h0,   4'd8, "hold_pre_rst", 32'h0,       1'b0, 1'b0, 3'd7);
        applyStimulus(1'b1, 5'b00001, 1'b0, 32'h0,        1'b0, 32'h0,   4'd8, "rst_in_hold", 32'h1000,     1'b0, 1'b0, 3'd0);
        applyStimulus(1'b0, 5'b00000, 1'b0, 32'h0,        1'b0, 32'h0,   4'd8, "reboot",      32'h1000,     1'b1, 1'b0, 3'd0);
        applyStimulus(1'b0, 5'b00000, 1'b0, 32'h0,        1'b0, 32'h0,   4'd8, "reboot_seq",  32'h1008,     1'b1, 1'b0, 3'd0);

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
